// File: rtl/rgb_pwm_pkg.sv
// rgb_pwm_pkg: mode encoding, parameter limits and range helper for rgb_pwm_ctrl
package rgb_pwm_pkg;
  typedef enum logic [1:0] {OFF = 2'b00, SOLID = 2'b01, BLINK = 2'b10, BREATHE = 2'b11} mode_t;
  localparam int NCH_MIN = 1, NCH_MAX = 8;
  localparam int PWM_W_MIN = 4, PWM_W_MAX = 12;
  localparam int PRE_W_MIN = 1, PRE_W_MAX = 16;
  localparam int BLINK_W_MIN = 1, BLINK_W_MAX = 16;
  function automatic bit in_range(input int v, input int lo, input int hi);
    return v >= lo && v <= hi;
  endfunction
endpackage

// File: rtl/rgb_pwm_chan.sv
// rgb_pwm_chan: per-channel staging/active config, level select and PWM compare (breathe path with RGB_PWM_BREATHE_EN)
module rgb_pwm_chan
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_halt,
  input  logic             i_wr,
  input  logic [PWM_W-1:0] i_duty,
  input  logic [1:0]       i_mode,
  input  logic             i_period_start,
  input  logic [PWM_W-1:0] i_pwm_cnt,
  input  logic             i_blink,
`ifdef RGB_PWM_BREATHE_EN
  input  logic [PWM_W-1:0] i_env,
`endif
  output logic             o_pwm
);
  mode_t            r_stg_mode, r_act_mode;
  logic [PWM_W-1:0] r_stg_duty, r_act_duty, w_level;
`ifdef RGB_PWM_BREATHE_EN
  logic [2*PWM_W-1:0] w_prod;
  assign w_prod = {{PWM_W{1'b0}}, r_act_duty} * {{PWM_W{1'b0}}, i_env};
`endif
  assign w_level = (r_act_mode == OFF || (r_act_mode == BLINK && !i_blink)) ? '0
`ifdef RGB_PWM_BREATHE_EN
                 : (r_act_mode == BREATHE) ? w_prod[2*PWM_W-1:PWM_W]
`endif
                 : r_act_duty;
  // i_period_start is already gated by halt, so active config cannot change while frozen
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stg_mode <= OFF;
      r_act_mode <= OFF;
      r_stg_duty <= '0;
      r_act_duty <= '0;
      o_pwm      <= 1'b0;
    end else begin
      if (i_wr) begin
        r_stg_mode <= mode_t'(i_mode);
        r_stg_duty <= i_duty;
      end
      if (i_period_start) begin
        r_act_mode <= r_stg_mode;
        r_act_duty <= r_stg_duty;
      end
      if (!i_halt) o_pwm <= w_level > i_pwm_cnt;
    end
  end
endmodule

// File: rtl/rgb_pwm_ctrl.sv
// rgb_pwm_ctrl: multi-channel LED PWM controller, solid/blink always, breathe only with RGB_PWM_BREATHE_EN
module rgb_pwm_ctrl
  import rgb_pwm_pkg::*;
#(
  parameter int NCH     = 3,
  parameter int PWM_W   = 8,
  parameter int PRE_W   = 4,
  parameter int BLINK_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic             wr_en,
  input  logic [2:0]       wr_ch,
  input  logic [PWM_W-1:0] wr_duty,
  input  logic [1:0]       wr_mode,
  output logic [NCH-1:0]   pwm,
  output logic             period_strobe
);
  if (!(in_range(NCH, NCH_MIN, NCH_MAX) && in_range(PWM_W, PWM_W_MIN, PWM_W_MAX) &&
        in_range(PRE_W, PRE_W_MIN, PRE_W_MAX) && in_range(BLINK_W, BLINK_W_MIN, BLINK_W_MAX))) begin : g_bad_param
    $error("rgb_pwm_ctrl: parameter out of range");
  end
  logic [PRE_W-1:0]   r_pre_cnt;
  logic [PWM_W-1:0]   r_pwm_cnt;
  logic [BLINK_W-1:0] r_blink_cnt;
  logic               w_tick, w_period_start;
  assign w_tick         = !halt && &r_pre_cnt;
  assign w_period_start = w_tick && &r_pwm_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre_cnt     <= '0;
      r_pwm_cnt     <= '0;
      r_blink_cnt   <= '0;
      period_strobe <= 1'b0;
    end else begin
      if (!halt) r_pre_cnt <= r_pre_cnt + 1'b1;
      if (w_tick) r_pwm_cnt <= r_pwm_cnt + 1'b1;
      if (w_period_start) r_blink_cnt <= r_blink_cnt + 1'b1;
      period_strobe <= w_period_start;
    end
  end
`ifdef RGB_PWM_BREATHE_EN
  logic [PWM_W-1:0] r_env, w_env_nxt;
  logic             r_dir;
  assign w_env_nxt = r_dir ? r_env - 1'b1 : r_env + 1'b1;
  // direction flips on the step that lands on an end point, so the peak is never repeated
  always_ff @(posedge clk) begin
    if (rst) begin
      r_env <= '0;
      r_dir <= 1'b0;
    end else if (w_period_start) begin
      r_env <= w_env_nxt;
      r_dir <= r_dir ? (w_env_nxt != '0) : (&w_env_nxt);
    end
  end
`endif
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    rgb_pwm_chan #(.PWM_W(PWM_W)) u_chan (
      .clk            (clk),
      .rst            (rst),
      .i_halt         (halt),
      .i_wr           (wr_en && wr_ch == 3'(i)),
      .i_duty         (wr_duty),
      .i_mode         (wr_mode),
      .i_period_start (w_period_start),
      .i_pwm_cnt      (r_pwm_cnt),
      .i_blink        (r_blink_cnt[BLINK_W-1]),
`ifdef RGB_PWM_BREATHE_EN
      .i_env          (r_env),
`endif
      .o_pwm          (pwm[i])
    );
  end
endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// tb_rgb_pwm_ctrl: directed self-checking bench for rgb_pwm_ctrl (PWM_W=4, PRE_W=1, BLINK_W=2)
module tb_rgb_pwm_ctrl;
  localparam int NCH = 3, PWM_W = 4, PRE_W = 1, BLINK_W = 2, PER = 32;
  logic             clk = 1'b0, rst = 1'b1, halt = 1'b0, wr_en = 1'b0;
  logic [2:0]       wr_ch = '0;
  logic [PWM_W-1:0] wr_duty = '0;
  logic [1:0]       wr_mode = '0;
  logic [NCH-1:0]   pwm;
  logic             period_strobe;
  int               n_run = 0, n_fail = 0, lat;
  always #5 clk = ~clk;
  rgb_pwm_ctrl #(.NCH(NCH), .PWM_W(PWM_W), .PRE_W(PRE_W), .BLINK_W(BLINK_W)) dut (
    .clk(clk), .rst(rst), .halt(halt), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_duty(wr_duty), .wr_mode(wr_mode), .pwm(pwm), .period_strobe(period_strobe)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic drive_wr(input int ch, input int mode, input int duty);
    wr_en   = 1'b1;
    wr_ch   = 3'(ch);
    wr_mode = 2'(mode);
    wr_duty = PWM_W'(duty);
  endtask
  task automatic cfg(input int ch, input int mode, input int duty);
    drive_wr(ch, mode, duty);
    @(negedge clk);
    wr_en = 1'b0;
  endtask
  task automatic wait_strobe(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_strobe && n < 200);
    check(tag, period_strobe, 1);
  endtask
  task automatic count_period(input string tag, input int e0, input int e1, input int e2,
                              input int wr_at, input int wch, input int wmode, input int wduty);
    int c[NCH];
    int s;
    int e[NCH];
    s = 0;
    e = '{e0, e1, e2};
    for (int ch = 0; ch < NCH; ch++) c[ch] = 0;
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      for (int ch = 0; ch < NCH; ch++) c[ch] += int'(pwm[ch]);
      s += int'(period_strobe);
      if (i == wr_at) drive_wr(wch, wmode, wduty);
      if (i == wr_at + 1) wr_en = 1'b0;
    end
    for (int ch = 0; ch < NCH; ch++) check($sformatf("%s_ch%0d", tag, ch), c[ch], e[ch]);
    check($sformatf("%s_strobe_once", tag), s, 1);
    check($sformatf("%s_strobe_end", tag), period_strobe, 1);
  endtask
  task automatic halt_period();
    int c0, c1, fz, s;
    logic [NCH-1:0] held;
    c0 = 0; c1 = 0; fz = 0; s = 0; held = '0;
    for (int i = 1; i <= PER + 37; i++) begin
      @(negedge clk);
      if (i <= 10 || i >= 48) begin
        c0 += int'(pwm[0]);
        c1 += int'(pwm[1]);
      end else fz += int'(pwm !== held);
      if (i < PER + 37) s += int'(period_strobe);
      if (i == 10) begin
        held = pwm;
        halt = 1'b1;
        drive_wr(1, 1, 1);
      end
      if (i == 11) wr_en = 1'b0;
      if (i == 47) halt = 1'b0;
    end
    check("halt_frozen", fz, 0);
    check("halt_held_val", held, 3'b011);
    check("halt_no_strobe", s, 0);
    check("halt_late_strobe", period_strobe, 1);
    check("halt_ch0", c0, 10);
    check("halt_ch1", c1, 18);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(negedge clk);
    check("rst_pwm", pwm, 0);
    check("rst_strobe", period_strobe, 0);
    rst = 1'b0;
    cfg(0, 1, 5);
    cfg(1, 1, 3);
    cfg(2, 2, 15);
    cfg(5, 1, 15);
    wait_strobe("first_start", lat);
    count_period("p1", 10, 6, 0, -1, 0, 0, 0);
    count_period("p2", 10, 6, 30, -1, 0, 0, 0);
    count_period("p3", 10, 6, 30, -1, 0, 0, 0);
    count_period("p4", 10, 6, 0, -1, 0, 0, 0);
    count_period("p5", 10, 6, 0, 30, 1, 1, 9);
    count_period("p6", 10, 6, 30, -1, 0, 0, 0);
    count_period("p7", 10, 18, 30, -1, 0, 0, 0);
    halt_period();
    count_period("p9", 10, 2, 0, -1, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 8) drive_wr(0, 1, 15);
      if (i == 9) wr_en = 1'b0;
      if (i == 10) begin
        check("pre_rst_pwm0", pwm[0], 1);
        rst  = 1'b1;
        halt = 1'b1;
        drive_wr(2, 1, 15);
      end
    end
    @(negedge clk);
    check("rst_mid_pwm", pwm, 0);
    check("rst_mid_strobe", period_strobe, 0);
    rst   = 1'b0;
    halt  = 1'b0;
    wr_en = 1'b0;
    wait_strobe("rst_restart", lat);
    check("rst_latency", lat, 32);
    count_period("r1", 0, 0, 0, 5, 2, 3, 15);
    for (int k = 2; k <= 33; k++) begin
      int exp;
`ifdef RGB_PWM_BREATHE_EN
      int e;
      e   = (k <= 15) ? k : (k <= 30) ? 30 - k : k - 30;
      exp = 2 * ((15 * e) >> 4);
`else
      exp = 30;
`endif
      count_period($sformatf("br%0d", k), 0, 0, exp, -1, 0, 0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/rgb_pwm_ctrl.md
RGB_PWM_CTRL -- requirements
Module: rgb_pwm_ctrl

Interface
REQ-001 SHALL take parameter NCH, default 3: number of LED channels, range 1..8.
REQ-002 SHALL take parameter PWM_W, default 8: duty and PWM counter width, range 4..12.
REQ-003 SHALL take parameter PRE_W, default 4: prescaler width, range 1..16; one PWM tick every 2^PRE_W clocks.
REQ-004 SHALL take parameter BLINK_W, default 6: blink counter width in PWM periods, range 1..16.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port halt, input, 1 bit: freezes all counters and outputs while high.
REQ-008 SHALL have port wr_en, input, 1 bit: configuration write strobe.
REQ-009 SHALL have port wr_ch, input, 3 bits: target channel index.
REQ-010 SHALL have port wr_duty, input, PWM_W bits: duty value to write.
REQ-011 SHALL have port wr_mode, input, 2 bits: mode to write; 00 off, 01 solid, 10 blink, 11 breathe.
REQ-012 SHALL have port pwm, output, NCH bits: registered per-channel PWM drive, active-high.
REQ-013 SHALL have port period_strobe, output, 1 bit: one-cycle pulse at each PWM period start.

Function
REQ-014 SHALL increment prescaler pre_cnt every clk; tick is asserted when pre_cnt is all-ones, then pre_cnt wraps to 0.
REQ-015 SHALL advance pwm_cnt by 1 on each tick, wrapping from 2^PWM_W-1 to 0; the wrap tick is the period start.
REQ-016 SHALL assert period_strobe, registered, for exactly one clk on the cycle after each period start.
REQ-017 SHALL, on wr_en with wr_ch < NCH, load wr_duty/wr_mode into that channel's staging register on the same edge; wr_ch >= NCH SHALL be ignored.
REQ-018 SHALL copy all staging registers to active registers at period start; a write on the period-start cycle SHALL take effect at the following period start.
REQ-019 SHALL compute per-channel level: off -> 0; solid -> duty; blink -> duty when blink_cnt MSB = 1, else 0; breathe -> (duty * env) >> PWM_W.
REQ-020 SHALL drive pwm[i] = (level_i > pwm_cnt), registered, one clk after pwm_cnt; duty 0 gives a constant low and all-ones duty gives high for 2^PWM_W-1 of 2^PWM_W ticks.
REQ-021 SHALL increment blink_cnt (BLINK_W bits, wrapping) once per period start.
REQ-022 SHALL step env (PWM_W bits) by 1 per period start, up when dir=0 and down when dir=1; reaching all-ones sets dir=1 and reaching 0 sets dir=0, with no overshoot.
REQ-023 SHALL, while halt=1, hold pre_cnt, pwm_cnt, blink_cnt, env, dir, active registers and pwm, and SHALL keep period_strobe low; staging writes SHALL still be accepted.
REQ-024 SHALL resume from the held state with no skipped or duplicated tick when halt falls.

Reset
REQ-025 SHALL, on rst=1 at a clk edge, clear all counters, env, dir, staging and active registers (modes off, duty 0), set pwm=0 and period_strobe=0, with rst overriding halt and wr_en.
REQ-026 SHALL discard an in-progress period or pending staged write on reset; the first tick after rst falls occurs 2^PRE_W clks later.

Configuration
REQ-027 SHALL, when macro RGB_PWM_BREATHE_EN is defined, implement breathe mode with the env/dir logic and multiplier.
REQ-028 SHALL, when RGB_PWM_BREATHE_EN is undefined, omit env/dir and the multiplier and treat mode 11 exactly as solid.

Structure
REQ-029 SHALL place the mode encoding typedef (OFF, SOLID, BLINK, BREATHE) and parameter range limits in package rgb_pwm_pkg.
REQ-030 SHALL implement per-channel staging, active registers, level computation and compare in sub-module rgb_pwm_chan, instantiated NCH times; prescaler, pwm_cnt, blink_cnt and env are shared in rgb_pwm_ctrl.

Verification
REQ-031 SHALL verify: PWM_W=4, PRE_W=1, ch0 solid duty 5 -> pwm[0] high 5 of every 16 ticks (10 of 32 clks) after the first period start.
REQ-032 SHALL verify: write ch1 duty 9 on the period-start cycle -> old value kept for one full period, new value from the next period.
REQ-033 SHALL verify: BLINK_W=2, blink duty 15 -> pwm high during 2 periods and low during 2 periods, repeating.
REQ-034 SHALL verify: breathe duty 15 with the macro -> env 0..15..0 triangle with no repeated peak step; without the macro -> identical to solid.
REQ-035 SHALL verify: halt held 37 clks mid-period -> pwm and counters frozen, period_strobe low, and the period completes exactly 37 clks late.
REQ-036 SHALL verify: wr_ch=5 with NCH=3 ignored; rst mid-period -> pwm=0 next clk and all channels off.
